// File: rtl/event_deframer_pkg.sv
// Shared definitions for the 128-bit event word: header pattern, field positions,
// widths and the deframer state encoding.
package event_deframer_pkg;

    localparam int ED_ID_BITS   = 6;
    localparam int ED_E_BITS    = 12;
    localparam int ED_T_BITS    = 20;
    localparam int ED_FINE_BITS = 3;
    localparam int ED_N_CHAN    = 8;

    // Top byte of a word: 5 framing ones plus the single-event flag.
    localparam logic [5:0] ED_HEADER = 6'b111111;

    localparam int ED_FINE_LSB   = 0;
    localparam int ED_COARSE_LSB = ED_FINE_BITS;
    localparam int ED_ENERGY_LSB = ED_T_BITS;
    localparam int ED_ID_LSB     = ED_T_BITS + ED_N_CHAN * ED_E_BITS;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_BODY,
        ST_HOLD
    } state_t;

    function automatic logic is_header(input logic [7:0] b);
        return b[7:2] == ED_HEADER;
    endfunction

endpackage

// File: rtl/event_deframer_adder_tree.sv
// Combinational sum of eight unsigned energy channels; result is exact
// (three extra bits cover the 8x growth).
module energy_adder_tree
    import event_deframer_pkg::*;
#(
    parameter int E_BITS = ED_E_BITS
) (
    input  logic [8*E_BITS-1:0] i_energy,
    output logic [E_BITS+2:0]   o_sum
);

    logic [E_BITS:0]   w_s01, w_s23, w_s45, w_s67;
    logic [E_BITS+1:0] w_s0123, w_s4567;

    always_comb begin
        w_s01   = {1'b0, i_energy[0*E_BITS +: E_BITS]} + {1'b0, i_energy[1*E_BITS +: E_BITS]};
        w_s23   = {1'b0, i_energy[2*E_BITS +: E_BITS]} + {1'b0, i_energy[3*E_BITS +: E_BITS]};
        w_s45   = {1'b0, i_energy[4*E_BITS +: E_BITS]} + {1'b0, i_energy[5*E_BITS +: E_BITS]};
        w_s67   = {1'b0, i_energy[6*E_BITS +: E_BITS]} + {1'b0, i_energy[7*E_BITS +: E_BITS]};
        w_s0123 = {1'b0, w_s01} + {1'b0, w_s23};
        w_s4567 = {1'b0, w_s45} + {1'b0, w_s67};
        o_sum   = {1'b0, w_s0123} + {1'b0, w_s4567};
    end

endmodule

// File: rtl/event_deframer.sv
// Byte-stream to event deframer: hunts for a header byte, collects 16 bytes,
// decodes the word into registered output fields and tracks alignment lock.
module event_deframer
    import event_deframer_pkg::*;
#(
    parameter int ID_BITS    = ED_ID_BITS,
    parameter int E_BITS     = ED_E_BITS,
    parameter int T_BITS     = ED_T_BITS,
    parameter int LOCK_COUNT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ID_BITS-1:0]  out_block_id,
    output logic [8*E_BITS-1:0] out_energy,
    output logic [E_BITS+2:0]   out_energy_sum,
    output logic [T_BITS-4:0]   out_coarse,
    output logic [2:0]          out_fine,
    output logic                locked,
    output logic [15:0]         frame_err
);

    localparam int EN_BITS   = ED_N_CHAN * E_BITS;
    localparam int CO_BITS   = T_BITS - ED_FINE_BITS;
    // Bits above the block id are framing only, so they are never kept.
    localparam int KEEP_BITS = ED_ID_LSB + ID_BITS;

    state_t               r_state, w_next_state;
    logic [3:0]           r_idx;
    logic [KEEP_BITS-1:0] r_shift;
    logic                 r_out_valid;
    logic                 r_locked;
    logic [7:0]           r_good_cnt;
    logic [15:0]          r_frame_err;
    logic [ID_BITS-1:0]   r_block_id;
    logic [EN_BITS-1:0]   r_energy;
    logic [E_BITS+2:0]    r_sum;
    logic [CO_BITS-1:0]   r_coarse;
    logic [2:0]           r_fine;

    logic                 w_accept, w_is_hdr, w_last, w_slot_free;
    logic                 w_load, w_load_from_hold;
    logic [KEEP_BITS-1:0] w_shifted, w_word;
    logic [E_BITS+2:0]    w_sum;

    assign in_ready    = (r_state != ST_HOLD);
    assign w_accept    = in_valid && in_ready;
    assign w_is_hdr    = is_header(in_data);
    assign w_last      = (r_state == ST_BODY) && w_accept && (r_idx == 4'd15);
    assign w_slot_free = !r_out_valid || out_ready;
    assign w_shifted   = {r_shift[KEEP_BITS-9:0], in_data};
    // In HOLD the last byte has already been shifted in, so the register is the word.
    assign w_word      = w_load_from_hold ? r_shift : w_shifted;

    energy_adder_tree #(
        .E_BITS(E_BITS)
    ) u_adder (
        .i_energy(w_word[ED_ENERGY_LSB +: EN_BITS]),
        .o_sum   (w_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_HUNT;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state     = r_state;
        w_load           = 1'b0;
        w_load_from_hold = 1'b0;
        case (r_state)
            ST_HUNT: begin
                if (w_accept && w_is_hdr) w_next_state = ST_BODY;
            end
            ST_BODY: begin
                if (w_last) begin
                    if (w_slot_free) begin
                        w_load       = 1'b1;
                        w_next_state = ST_HUNT;
                    end else begin
                        w_next_state = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    w_load           = 1'b1;
                    w_load_from_hold = 1'b1;
                    w_next_state     = ST_HUNT;
                end
            end
            default: w_next_state = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_shift     <= '0;
            r_locked    <= 1'b0;
            r_good_cnt  <= '0;
            r_frame_err <= '0;
        end else if (w_accept) begin
            if (r_state == ST_HUNT) begin
                if (w_is_hdr) begin
                    r_shift <= w_shifted;
                    r_idx   <= 4'd1;
                end else if (r_locked) begin
                    if (r_frame_err != 16'hFFFF) r_frame_err <= r_frame_err + 16'd1;
                    r_locked   <= 1'b0;
                    r_good_cnt <= '0;
                end
            end else begin
                // Header-looking bytes inside a word are plain data; idx wraps to 0 after byte 15.
                r_shift <= w_shifted;
                r_idx   <= r_idx + 4'd1;
                if (r_idx == 4'd15) begin
                    if (int'(r_good_cnt) < LOCK_COUNT) r_good_cnt <= r_good_cnt + 8'd1;
                    if (int'(r_good_cnt) + 1 >= LOCK_COUNT) r_locked <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_block_id  <= '0;
            r_energy    <= '0;
            r_sum       <= '0;
            r_coarse    <= '0;
            r_fine      <= '0;
        end else begin
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_block_id  <= w_word[ED_ID_LSB +: ID_BITS];
                r_energy    <= w_word[ED_ENERGY_LSB +: EN_BITS];
                r_sum       <= w_sum;
                r_coarse    <= w_word[ED_COARSE_LSB +: CO_BITS];
                r_fine      <= w_word[ED_FINE_LSB +: ED_FINE_BITS];
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid      = r_out_valid;
    assign out_block_id   = r_block_id;
    assign out_energy     = r_energy;
    assign out_energy_sum = r_sum;
    assign out_coarse     = r_coarse;
    assign out_fine       = r_fine;
    assign locked         = r_locked;
    assign frame_err      = r_frame_err;

endmodule

// File: tb/tb_event_deframer.sv
// Self-checking bench for event_deframer: fixed vectors, directed corner
// sequences and randomized traffic against a byte-queue reference model.
module tb_event_deframer;

    localparam int LOCK = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [5:0]  out_block_id;
    logic [95:0] out_energy;
    logic [14:0] out_energy_sum;
    logic [16:0] out_coarse;
    logic [2:0]  out_fine;
    logic        locked;
    logic [15:0] frame_err;

    event_deframer #(
        .ID_BITS(6), .E_BITS(12), .T_BITS(20), .LOCK_COUNT(LOCK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_block_id(out_block_id), .out_energy(out_energy),
        .out_energy_sum(out_energy_sum), .out_coarse(out_coarse),
        .out_fine(out_fine), .locked(locked), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  id;
        logic [95:0] en;
        logic [16:0] co;
        logic [2:0]  fi;
        logic [14:0] sum;
    } vec_t;

    vec_t tbl[6];

    int n_vec = 0;
    int n_err = 0;
    bit rand_ordy = 0;

    // Reference model state: collected bytes of the word in progress, a pending
    // completed word waiting for the slot, and the presented event.
    logic [7:0]   m_bytes[$];
    bit           m_hold;
    logic [127:0] m_hold_word;
    bit           m_ov;
    logic [127:0] m_word;
    bit           m_locked;
    int           m_good;
    int           m_err;

    // Events actually taken from the DUT, as {id, energy, coarse, fine}.
    int           dut_events = 0;
    logic [127:0] dut_q[$];

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            dut_events++;
            dut_q.push_back(128'({out_block_id, out_energy, out_coarse, out_fine}));
        end
    end

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [127:0] build(input vec_t v);
        return {5'b11111, 1'b1, v.id, v.en, v.co, v.fi};
    endfunction

    function automatic logic [14:0] ref_sum(input logic [127:0] w);
        int s = 0;
        for (int k = 0; k < 8; k++) s += int'(w[20 + 12*k +: 12]);
        return 15'(s);
    endfunction

    function automatic void model_reset();
        m_bytes.delete();
        m_hold = 0; m_hold_word = '0;
        m_ov = 0; m_word = '0;
        m_locked = 0; m_good = 0; m_err = 0;
    endfunction

    function automatic void model_step();
        bit hs = m_ov && out_ready;
        bit ld = 0;
        logic [127:0] lw = '0;
        if (m_hold && out_ready) begin
            ld = 1; lw = m_hold_word; m_hold = 0;
        end else if (in_valid && !m_hold) begin
            if (m_bytes.size() == 0) begin
                if (in_data[7:2] == 6'h3F) m_bytes.push_back(in_data);
                else if (m_locked) begin
                    if (m_err < 65535) m_err++;
                    m_locked = 0; m_good = 0;
                end
            end else begin
                m_bytes.push_back(in_data);
                if (m_bytes.size() == 16) begin
                    for (int i = 0; i < 16; i++) lw = {lw[119:0], m_bytes[i]};
                    m_bytes.delete();
                    m_good++;
                    if (m_good >= LOCK) m_locked = 1;
                    if (!m_ov || out_ready) ld = 1;
                    else begin m_hold = 1; m_hold_word = lw; end
                end
            end
        end
        if (ld) begin m_ov = 1; m_word = lw; end
        else if (hs) m_ov = 0;
    endfunction

    function automatic void check_outputs();
        chk("out_valid", 128'(out_valid), 128'(m_ov));
        chk("locked", 128'(locked), 128'(m_locked));
        chk("frame_err", 128'(frame_err), 128'(m_err));
        if (m_ov) begin
            chk("block_id", 128'(out_block_id), 128'(m_word[121:116]));
            chk("energy", 128'(out_energy), 128'(m_word[115:20]));
            chk("energy_sum", 128'(out_energy_sum), 128'(ref_sum(m_word)));
            chk("coarse", 128'(out_coarse), 128'(m_word[19:3]));
            chk("fine", 128'(out_fine), 128'(m_word[2:0]));
        end
    endfunction

    task automatic tick();
        if (rand_ordy) out_ready = ($urandom_range(0, 3) != 0);
        chk("in_ready", 128'(in_ready), 128'(!m_hold));
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit acc;
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        do begin
            acc = !m_hold;
            tick();
            n++;
        end while (!acc && n < 100);
        if (!acc) chk("accept_timeout", 128'(0), 128'(1));
    endtask

    task automatic send_word(input logic [127:0] w, input bit gaps);
        logic [7:0] b;
        for (int i = 0; i < 16; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle(1);
            b = w[127 - 8*i -: 8];
            send_byte(b);
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_locked", 128'(locked), 128'(0));
        chk("rst_frame_err", 128'(frame_err), 128'(0));
        chk("rst_fields", 128'({out_block_id, out_energy, out_energy_sum, out_coarse, out_fine}), 128'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_tbl(input string tag, input vec_t v);
        chk({tag, "_valid"}, 128'(out_valid), 128'(1));
        chk({tag, "_id"}, 128'(out_block_id), 128'(v.id));
        chk({tag, "_energy"}, 128'(out_energy), 128'(v.en));
        chk({tag, "_sum"}, 128'(out_energy_sum), 128'(v.sum));
        chk({tag, "_coarse"}, 128'(out_coarse), 128'(v.co));
        chk({tag, "_fine"}, 128'(out_fine), 128'(v.fi));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] w, w1, w2;
        logic [7:0]   b;
        int           sz;
        vec_t         v;

        tbl[0] = '{6'h2A, {8{12'h100}}, 17'h1ABCD, 3'd5, 15'h0800};
        tbl[1] = '{6'h3F, {8{12'hFFF}}, 17'h1FFFF, 3'd7, 15'd32760};
        tbl[2] = '{6'h00, 96'h0, 17'h00000, 3'd0, 15'd0};
        tbl[3] = '{6'h15, {12'h777, 12'h666, 12'h555, 12'h444, 12'h333, 12'h222, 12'h111, 12'h000},
                   17'h12345, 3'd2, 15'd7644};
        tbl[4] = '{6'h01, {84'h0, 12'hFFF}, 17'h00001, 3'd1, 15'd4095};
        tbl[5] = '{6'h20, {12'h800, 12'h001, 72'h0}, 17'h10000, 3'd4, 15'd2049};

        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Two back-to-back words; lock after the second.
        out_ready = 1'b1;
        w = build(tbl[0]);
        send_word(w, 0);
        check_tbl("t36_first", tbl[0]);
        chk("t36_locked_first", 128'(locked), 128'(0));
        send_word(w, 0);
        check_tbl("t36_second", tbl[0]);
        chk("t36_locked_second", 128'(locked), 128'(1));

        // Non-header byte while locked.
        send_byte(8'h7F);
        in_valid = 1'b0;
        chk("t38_frame_err", 128'(frame_err), 128'(1));
        chk("t38_locked", 128'(locked), 128'(0));
        send_word(build(tbl[3]), 0);
        check_tbl("t38_next", tbl[3]);
        idle(2);

        // Junk before a word while unlocked.
        do_reset();
        sz = dut_events;
        for (int i = 0; i < 3; i++) send_byte(8'h00);
        send_word(build(tbl[2]), 0);
        check_tbl("t37_word", tbl[2]);
        idle(2);
        chk("t37_events", 128'(dut_events - sz), 128'(1));
        chk("t37_frame_err", 128'(frame_err), 128'(0));

        foreach (tbl[i]) begin
            send_word(build(tbl[i]), 1);
            check_tbl($sformatf("tbl%0d", i), tbl[i]);
            idle(1);
        end

        // Backpressure across two words.
        out_ready = 1'b0;
        sz = dut_events;
        w1 = build(tbl[3]);
        w2 = build(tbl[4]);
        send_word(w1, 0);
        send_word(w2, 0);
        idle(3);
        chk("t39_in_ready", 128'(in_ready), 128'(0));
        chk("t39_valid", 128'(out_valid), 128'(1));
        chk("t39_held_id", 128'(out_block_id), 128'(tbl[3].id));
        chk("t39_held_coarse", 128'(out_coarse), 128'(tbl[3].co));
        out_ready = 1'b1;
        idle(3);
        chk("t39_events", 128'(dut_events - sz), 128'(2));
        if (dut_q.size() >= sz + 2) begin
            chk("t39_order_first", dut_q[sz], 128'(w1[121:0]));
            chk("t39_order_second", dut_q[sz + 1], 128'(w2[121:0]));
        end

        // Reset in the middle of a word.
        sz = dut_events;
        w = build(tbl[1]);
        for (int i = 0; i < 10; i++) begin
            b = w[127 - 8*i -: 8];
            send_byte(b);
        end
        do_reset();
        idle(20);
        chk("t41_no_event", 128'(dut_events - sz), 128'(0));
        send_word(w, 0);
        check_tbl("t41_after", tbl[1]);
        idle(2);
        chk("t41_events", 128'(dut_events - sz), 128'(1));

        // Randomized traffic with junk, gaps and random backpressure.
        rand_ordy = 1;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                for (int j = 0; j < int'($urandom_range(1, 2)); j++) begin
                    b = 8'($urandom);
                    if (b[7:2] == 6'h3F) b[7] = 1'b0;
                    send_byte(b);
                end
            end
            v.id  = 6'($urandom);
            v.en  = ($urandom_range(0, 5) == 0) ? {8{12'hFFF}} : {$urandom, $urandom, $urandom};
            v.co  = 17'($urandom);
            v.fi  = 3'($urandom);
            v.sum = '0;
            send_word(build(v), 1);
        end
        rand_ordy = 0;
        out_ready = 1'b1;
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
